// File: rtl/heavyhash_row_collector.sv
// Collects PE row sums over ROWS/NUM_PE passes, reduces each to a nibble,
// packs them into the product vector and returns product XOR job hash.
module heavyhash_row_collector #(
  parameter int NUM_PE = 16,
  parameter int ROWS   = 64,
  parameter int SHIFT  = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4*ROWS-1:0]      hash_in,
  input  logic                   hash_valid,
  output logic                   hash_ready,
  input  logic                   pe_valid,
  input  logic [NUM_PE*14-1:0]   pe_sums,
  output logic                   pe_clr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*ROWS-1:0]      out_data,
  output logic                   err_unexpected
);

  localparam int PASSES = ROWS / NUM_PE;
  localparam int PCW    = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int VW     = 4 * ROWS;
  localparam logic [PCW-1:0] LAST_PASS = PCW'(PASSES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_OUTPUT
  } state_t;

  state_t          state_reg;
  logic [PCW-1:0]  pass_cnt_reg;
  logic [VW-1:0]   hash_reg;
  logic [VW-1:0]   prod_reg;
  logic [VW-1:0]   prod_next;
  logic [3:0]      nib [NUM_PE];

  // Each PE sum is scaled down and only the low nibble of the quotient is kept.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PE; gi++) begin : g_nib
      assign nib[gi] = 4'(pe_sums[14*gi +: 14] >> SHIFT);
    end
  endgenerate

  // Row r belongs to pass r/NUM_PE on lane r%NUM_PE; rows of other passes hold.
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      localparam int PASS_OF = gi / NUM_PE;
      localparam int LANE    = gi % NUM_PE;
      assign prod_next[4*gi +: 4] = (pass_cnt_reg == PCW'(PASS_OF)) ? nib[LANE]
                                                                   : prod_reg[4*gi +: 4];
    end
  endgenerate

  assign hash_ready = (state_reg == ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      pass_cnt_reg   <= '0;
      hash_reg       <= '0;
      prod_reg       <= '0;
      out_data       <= '0;
      out_valid      <= 1'b0;
      pe_clr         <= 1'b0;
      err_unexpected <= 1'b0;
    end else begin
      pe_clr <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (pe_valid) begin
            err_unexpected <= 1'b1;
          end
          if (hash_valid) begin
            hash_reg     <= hash_in;
            prod_reg     <= '0;
            pass_cnt_reg <= '0;
            state_reg    <= ST_COLLECT;
          end
        end

        ST_COLLECT: begin
          if (pe_valid) begin
            pe_clr   <= 1'b1;
            prod_reg <= prod_next;
            if (pass_cnt_reg == LAST_PASS) begin
              out_data  <= prod_next ^ hash_reg;
              out_valid <= 1'b1;
              state_reg <= ST_OUTPUT;
            end else begin
              pass_cnt_reg <= pass_cnt_reg + PCW'(1);
            end
          end
        end

        ST_OUTPUT: begin
          if (pe_valid) begin
            err_unexpected <= 1'b1;
          end
          // Result stays put until taken; IDLE (and hash_ready) follow one cycle later.
          if (out_ready) begin
            out_valid <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_heavyhash_row_collector.sv
// Randomised and directed bench for heavyhash_row_collector with a job-level
// reference model compared against the DUT outputs on every cycle.
module tb_heavyhash_row_collector;

  localparam int NUM_PE = 16;
  localparam int ROWS   = 64;
  localparam int SHIFT  = 10;
  localparam int PASSES = ROWS / NUM_PE;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [255:0]         hash_in = '0;
  logic                 hash_valid = 1'b0;
  logic                 hash_ready;
  logic                 pe_valid = 1'b0;
  logic [NUM_PE*14-1:0] pe_sums = '0;
  logic                 pe_clr;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [255:0]         out_data;
  logic                 err_unexpected;

  heavyhash_row_collector #(.NUM_PE(NUM_PE), .ROWS(ROWS), .SHIFT(SHIFT)) dut (
    .clk            (clk),
    .rst            (rst),
    .hash_in        (hash_in),
    .hash_valid     (hash_valid),
    .hash_ready     (hash_ready),
    .pe_valid       (pe_valid),
    .pe_sums        (pe_sums),
    .pe_clr         (pe_clr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .err_unexpected (err_unexpected)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int clr_cnt = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: job-level view (mode 0 idle, 1 collecting, 2 holding result).
  int           m_mode = 0;
  int           m_pass = 0;
  logic [3:0]   m_nib [ROWS];
  logic [255:0] m_hash = '0;
  logic [255:0] m_data = '0;
  logic         m_valid = 1'b0;
  logic         m_clr = 1'b0;
  logic         m_err = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_mode = 0; m_pass = 0; m_hash = '0; m_data = '0;
        m_valid = 1'b0; m_clr = 1'b0; m_err = 1'b0;
      end else begin
        m_clr = 1'b0;
        if (m_mode == 0) begin
          if (pe_valid) m_err = 1'b1;
          if (hash_valid) begin
            m_hash = hash_in;
            for (int r = 0; r < ROWS; r++) m_nib[r] = 4'h0;
            m_pass = 0;
            m_mode = 1;
          end
        end else if (m_mode == 1) begin
          if (pe_valid) begin
            m_clr = 1'b1;
            for (int i = 0; i < NUM_PE; i++)
              m_nib[m_pass*NUM_PE + i] = 4'((int'(pe_sums[14*i +: 14]) / (1 << SHIFT)) % 16);
            if (m_pass == PASSES - 1) begin
              for (int r = 0; r < ROWS; r++) m_data[4*r +: 4] = m_nib[r] ^ m_hash[4*r +: 4];
              m_valid = 1'b1;
              m_mode  = 2;
            end else begin
              m_pass = m_pass + 1;
            end
          end
        end else begin
          if (pe_valid) m_err = 1'b1;
          if (out_ready) begin
            m_valid = 1'b0;
            m_mode  = 0;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("out_valid", {255'd0, out_valid}, {255'd0, m_valid});
        check("out_data", out_data, m_data);
        check("hash_ready", {255'd0, hash_ready}, {255'd0, (m_mode == 0)});
        check("pe_clr", {255'd0, pe_clr}, {255'd0, m_clr});
        check("err_unexpected", {255'd0, err_unexpected}, {255'd0, m_err});
      end
      if (pe_clr === 1'b1) clr_cnt++;
    end
  end

  task automatic send_hash(input logic [255:0] h);
    bit ok;
    ok = 1'b0;
    hash_in    = h;
    hash_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (hash_ready === 1'b1) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    hash_valid = 1'b0;
    check("hash_accept", {255'd0, ok}, 256'd1);
  endtask

  // kind 0: constant sum c; kind 1: sum = ((p*16+i)%16)<<10; kind 2: random sums
  task automatic send_pass(input int p, input int kind, input logic [13:0] c);
    for (int i = 0; i < NUM_PE; i++) begin
      if (kind == 0)      pe_sums[14*i +: 14] = c;
      else if (kind == 1) pe_sums[14*i +: 14] = 14'(((p*16 + i) % 16) << 10);
      else                pe_sums[14*i +: 14] = 14'($urandom_range(0, 16383));
    end
    pe_valid = 1'b1;
    @(negedge clk);
    pe_valid = 1'b0;
  endtask

  task automatic run_job(input logic [255:0] h, input int kind, input logic [13:0] c,
                         input int bp, output logic [255:0] got);
    int base;
    base = clr_cnt;
    send_hash(h);
    for (int p = 0; p < PASSES; p++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_pass(p, kind, c);
    end
    check("latency_out_valid", {255'd0, out_valid}, 256'd1);
    got = out_data;
    // Backpressure with a competing hash that must not be taken.
    for (int k = 0; k < bp; k++) begin
      hash_in    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      hash_valid = 1'b1;
      @(negedge clk);
      check("bp_hold_data", out_data, got);
      check("bp_hash_ready", {255'd0, hash_ready}, 256'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready  = 1'b0;
    hash_valid = 1'b0;
    check("after_hs_out_valid", {255'd0, out_valid}, 256'd0);
    check("after_hs_hash_ready", {255'd0, hash_ready}, 256'd1);
    check("pe_clr_pulses", 256'(clr_cnt - base), 256'(PASSES));
  endtask

  logic [255:0] got;
  logic [255:0] h;
  logic [255:0] pat;

  initial begin
    pat = {4{64'hFEDCBA9876543210}};
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;
    check("reset_out_valid", {255'd0, out_valid}, 256'd0);
    check("reset_out_data", out_data, 256'd0);
    check("reset_hash_ready", {255'd0, hash_ready}, 256'd1);
    check("reset_err", {255'd0, err_unexpected}, 256'd0);
    check("reset_pe_clr", {255'd0, pe_clr}, 256'd0);

    run_job(256'd0, 0, 14'h0400, 0, got);
    check("t1_literal", got, {64{4'h1}});
    check("t1_model", m_data, {64{4'h1}});

    run_job({256{1'b1}}, 0, 14'h3FFF, 1, got);
    check("t2_literal", got, 256'd0);

    h = {8{32'hDEADBEEF}};
    run_job(h, 0, 14'h03FF, 0, got);
    check("t3_literal", got, {8{32'hDEADBEEF}});

    run_job(256'd0, 1, 14'h0, 0, got);
    check("t4_literal", got, pat);
    check("t4_model", m_data, pat);

    run_job(256'd0, 1, 14'h0, 5, got);
    check("t5_literal", got, pat);

    // Spurious pe_valid in IDLE.
    send_pass(0, 0, 14'h3FFF);
    check("t6_err_set", {255'd0, err_unexpected}, 256'd1);
    check("t6_idle_kept", {255'd0, hash_ready}, 256'd1);
    check("t6_no_clr", {255'd0, pe_clr}, 256'd0);

    // Reset after two passes of a job.
    send_hash({8{$urandom}});
    send_pass(0, 2, 14'h0);
    send_pass(1, 2, 14'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_rst_out_valid", {255'd0, out_valid}, 256'd0);
    check("t6_rst_err", {255'd0, err_unexpected}, 256'd0);
    check("t6_rst_hash_ready", {255'd0, hash_ready}, 256'd1);
    check("t6_rst_out_data", out_data, 256'd0);
    run_job(256'd0, 1, 14'h0, 0, got);
    check("t6_after_rst", got, pat);

    // Randomised jobs, checked cycle by cycle against the model.
    for (int j = 0; j < 30; j++) begin
      h = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run_job(h, 2, 14'h0, int'($urandom_range(0, 4)), got);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/heavyhash_row_collector.md
Name: heavyhash_row_collector

Overview:
- Stage directly downstream of the PE array in the oBTC miner datapath.
- Captures the 14-bit row accumulations from NUM_PE parallel PEs over ROWS/NUM_PE passes and reduces each one to a 4-bit nibble (sum >> 10).
- Packs the nibbles into a 256-bit product vector, XORs it with the SHA3 hash that fed the PEs, and hands the result to the final SHA3 stage over a valid/ready handshake.
- Issues a pe_clr pulse after each capture so the PEs restart accumulation for the next row group.

Parameters:
- NUM_PE, 16, number of PEs whose sums are presented per pass; ROWS must be divisible by NUM_PE.
- ROWS, 64, matrix rows, equal to the number of output nibbles.
- SHIFT, 10, right-shift applied to each 14-bit sum; the result is truncated to 4 bits.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- hash_in  in  256  SHA3 hash for the job; latched on the hash handshake.
- hash_valid  in  1  a new job hash is presented.
- hash_ready  out  1  high only in IDLE.
- pe_valid  in  1  one-cycle pulse: pe_sums holds the final accumulations of the current pass.
- pe_sums  in  NUM_PE*14  PE i sum is at bits [14i+13:14i].
- pe_clr  out  1  one-cycle pulse to the PEs' clr input.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  256  product vector XOR hash.
- err_unexpected  out  1  sticky flag: pe_valid arrived outside COLLECT.

Behaviour:
- Reset values:
  - state = IDLE, pass_cnt = 0.
  - hash_reg, prod_reg and out_data = 0.
  - out_valid, pe_clr and err_unexpected = 0.
  - hash_ready = 1 in the first cycle after reset deasserts.
- States: IDLE, COLLECT, OUTPUT.
- IDLE:
  - hash_ready = 1.
  - On hash_valid: latch hash_in into hash_reg, clear prod_reg, set pass_cnt = 0, go to COLLECT.
- COLLECT:
  - hash_ready = 0.
  - On pe_valid, for each i in 0..NUM_PE-1: row r = pass_cnt*NUM_PE + i, and prod_reg[4r+3:4r] = pe_sums[14i+13:14i] >> SHIFT, truncated to 4 bits (bits 13:10 at the default SHIFT).
  - pe_clr is asserted in the cycle after every accepted pe_valid, including the last pass.
  - If pass_cnt < ROWS/NUM_PE-1: increment pass_cnt.
  - Else (last pass): register out_data = prod_reg_next XOR hash_reg, set out_valid = 1, go to OUTPUT.
  - Latency: last pe_valid at cycle T gives out_valid = 1 at T+1.
- OUTPUT:
  - out_valid and out_data are held stable until out_ready = 1.
  - Handshake cycle: out_valid = 0 and state = IDLE at the next edge, so hash_ready = 1 one cycle after the handshake.
  - There is no bypass: a new hash cannot be accepted in the handshake cycle itself.
- pe_valid in IDLE or OUTPUT:
  - Data is ignored and no pe_clr is issued.
  - err_unexpected is set and stays set until rst.
- hash_valid outside IDLE is not accepted; hash_ready = 0 tells the source to hold.
- pass_cnt width is clog2(ROWS/NUM_PE), minimum 1 bit. NUM_PE = ROWS gives a single pass.
- rst mid-operation: returns to IDLE the next cycle with all outputs at reset values; partial nibbles and the latched hash are discarded.
- Bit order: nibble 0 is out_data[3:0]; the XOR is a plain 256-bit bitwise XOR with hash_in bit order preserved.

Test Plan:
1. Defaults, hash_in = 0, 4 passes with all sums = 14'h0400 -> out_data = 64 nibbles of 1 (256'h1111...1), out_valid at T+1 after the 4th pe_valid, 4 pe_clr pulses.
2. Defaults, hash_in = all F, all sums = 14'h3FFF -> out_data = 0.
3. All sums = 14'h03FF, hash_in = 256'hDEADBEEF...(repeated) -> out_data = hash_in (every nibble truncates to 0).
4. Pass p, PE i sum = ((p*16+i) mod 16) << 10, hash_in = 0 -> out_data = 256'hFEDCBA9876543210 repeated 4 times.
5. Backpressure: out_ready held low 5 cycles -> out_valid = 1 and out_data stable, hash_ready = 0, a concurrent hash_valid is not accepted; out_ready = 1 -> next cycle out_valid = 0, hash_ready = 1.
6. Error and reset:
   - pe_valid in IDLE -> err_unexpected = 1, state unchanged, no pe_clr.
   - rst after 2 passes of a job -> IDLE, out_valid = 0, err_unexpected = 0.
   - A full new job then gives the correct result.
